// File: rtl/upsample_pkg.sv
// Shared definitions for the upsampling input-buffer controller: FSM states,
// tile size codes and the code-to-edge-length decode.
package upsample_pkg;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_e;

  localparam logic [2:0] SZ_4X4 = 3'b000;
  localparam logic [2:0] SZ_8X8 = 3'b001;

  localparam int ADDR_W = 14;
  localparam int COORD_W = 6;

  // Tile edge length N for a size code; 0 flags an unsupported code.
  function automatic logic [3:0] size_to_n(input logic [2:0] code);
    case (code)
      SZ_4X4:  return 4'd4;
      SZ_8X8:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/win_scan_counter.sv
// Walks the top-left corner of each 2x2 window over an N x N tile in raster
// order; last_o is registered together with the coordinates.
module win_scan_counter
  import upsample_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               adv_i,
  input  logic [3:0]         n_i,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [COORD_W-1:0] row_o,
  output logic [COORD_W-1:0] col_o,
  output logic               last_o
);

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
  logic               last_q, last_d;
  logic [COORD_W-1:0] lim;

  assign lim = COORD_W'(n_i) - COORD_W'(2);

  always_comb begin
    addr_d = addr_q;
    row_d  = row_q;
    col_d  = col_q;
    last_d = last_q;
    if (clr_i) begin
      addr_d = '0;
      row_d  = '0;
      col_d  = '0;
      last_d = 1'b0;
    end else if (adv_i) begin
      // The +2 on a row wrap skips the right-edge pixel, which is never a corner.
      if (col_q == lim) begin
        col_d  = '0;
        row_d  = row_q + COORD_W'(1);
        addr_d = addr_q + ADDR_W'(2);
      end else begin
        col_d  = col_q + COORD_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
      last_d = (row_d == lim) && (col_d == lim);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
      last_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      row_q  <= row_d;
      col_q  <= col_d;
      last_q <= last_d;
    end
  end

  assign addr_o = addr_q;
  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = last_q;

endmodule

// File: rtl/upsample_ctrl.sv
// Tile sequencer for reg_input: requests and loads a tile, then presents every
// 2x2 window to the interpolator under valid/ready, aligned with dout1..4.
module upsample_ctrl
  import upsample_pkg::*;
#(
  parameter int length        = 16,
  parameter int number_of_row = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          size_upsample,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                ld_req,
  input  logic                ld_ack,
  output logic                en_write_in,
  output logic [ADDR_W-1:0]   addr_input,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [COORD_W-1:0]  win_row,
  output logic [COORD_W-1:0]  win_col,
  output logic                win_last
);

  if (length < 1) begin : g_bad_length
    $error("upsample_ctrl: length must be positive");
  end

  state_e     state_q;
  logic [3:0] n_q;
  logic       busy_q, done_q, err_q, ld_req_q, win_valid_q, pend_q;
  logic [3:0] start_n;
  logic       start_ok, hs, scan_clr, scan_adv;

  // A code is only accepted if its tile fits in the buffer.
  assign start_n  = size_to_n(size_upsample);
  assign start_ok = (start_n != 4'd0) &&
                    ((int'(start_n) * int'(start_n)) <= number_of_row);

  assign hs       = win_valid_q && win_ready;
  assign scan_clr = (state_q == S_LOAD) && ld_ack;
  assign scan_adv = (state_q == S_SCAN) && hs && !win_last;

  win_scan_counter u_scan (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (scan_clr),
    .adv_i  (scan_adv),
    .n_i    (n_q),
    .addr_o (addr_input),
    .row_o  (win_row),
    .col_o  (win_col),
    .last_o (win_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ld_req_q    <= 1'b0;
      win_valid_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              n_q      <= start_n;
              ld_req_q <= 1'b1;
              busy_q   <= 1'b1;
              state_q  <= S_LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (ld_ack) begin
            ld_req_q <= 1'b0;
            pend_q   <= 1'b1;
            state_q  <= S_SCAN;
          end
        end
        S_SCAN: begin
          // pend: address went out last edge, buffer dout is captured this edge.
          if (pend_q) begin
            win_valid_q <= 1'b1;
            pend_q      <= 1'b0;
          end else if (hs) begin
            win_valid_q <= 1'b0;
            if (win_last) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              pend_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ld_req      = ld_req_q;
  assign win_valid   = win_valid_q;
  assign en_write_in = ld_req_q & ld_ack;

endmodule

// File: tb/tb_upsample_ctrl.sv
// Scoreboard bench for upsample_ctrl: stimulus pushes expected windows, a
// negedge monitor pops and compares on every accepted window.
module tb_upsample_ctrl;
  import upsample_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, ld_ack, win_ready;
  logic [2:0]  size_upsample;
  logic        busy, done, err, ld_req, en_write_in, win_valid, win_last;
  logic [13:0] addr_input;
  logic [5:0]  win_row, win_col;

  upsample_ctrl #(.length(16), .number_of_row(64)) dut (
    .clk(clk), .rst(rst), .start(start), .size_upsample(size_upsample),
    .busy(busy), .done(done), .err(err), .ld_req(ld_req), .ld_ack(ld_ack),
    .en_write_in(en_write_in), .addr_input(addr_input), .win_valid(win_valid),
    .win_ready(win_ready), .win_row(win_row), .win_col(win_col), .win_last(win_last)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int row; int col; int last;} win_t;
  win_t q[$];
  int   addr_log[$];
  int   errors = 0, checks = 0, done_cnt = 0, wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_tile(input int n);
    for (int r = 0; r < n - 1; r++)
      for (int c = 0; c < n - 1; c++)
        q.push_back('{r * n + c, r, c, int'((r == n - 2) && (c == n - 2))});
  endtask

  // Monitor: decoupled from stimulus, checks every accepted window.
  always @(negedge clk) begin
    win_t e;
    if (!rst) begin
      if (done) done_cnt++;
      if (en_write_in) wr_cnt++;
      if (win_valid && win_ready) begin
        addr_log.push_back(int'(addr_input));
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_window: got addr %0d expected none", addr_input);
        end else begin
          e = q.pop_front();
          chk("win_addr", 32'(addr_input), e.addr);
          chk("win_row",  32'(win_row),    e.row);
          chk("win_col",  32'(win_col),    e.col);
          chk("win_last", 32'(win_last),   e.last);
        end
      end
    end
  end

  task automatic begin_tile(input logic [2:0] code, input int n, input int ack_dly, input bit poke);
    start = 1'b1;
    size_upsample = code;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ld_req_after_start", 32'(ld_req), 1);
    chk("busy_after_start",   32'(busy),   1);
    for (int i = 0; i < ack_dly - 1; i++) begin
      start = poke && (i == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    push_tile(n);
    ld_ack = 1'b1;
    @(posedge clk); #1;
    ld_ack = 1'b0;
    if (poke) begin
      start = 1'b1;
      size_upsample = SZ_4X4;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(posedge clk); #1;
      got = done;
    end
    chk("done_seen", 32'(got), 1);
    @(posedge clk); #1;
    chk("busy_low_after_done", 32'(busy), 0);
  endtask

  task automatic wait_win(input int r, input int c);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (win_valid && (int'(win_row) == r) && (int'(win_col) == c)) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("window_reached", 32'(got), 1);
  endtask

  initial begin
    int exp4[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int dc;
    rst = 1'b1; start = 1'b0; size_upsample = 3'b000; ld_ack = 1'b0; win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", 32'({busy, done, err, ld_req, win_valid, win_last, en_write_in}), 0);
    chk("reset_addr",  32'(addr_input), 0);
    chk("reset_rc",    32'({win_row, win_col}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Unsupported size code
    start = 1'b1; size_upsample = 3'b010;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse",  32'(err),    1);
    chk("err_ld_req", 32'(ld_req), 0);
    chk("err_busy",   32'(busy),   0);
    @(posedge clk); #1;
    chk("err_one_cycle", 32'(err),  0);
    chk("err_busy_later", 32'(busy), 0);

    // 4x4, ack 3 cycles after ld_req
    addr_log.delete();
    begin_tile(SZ_4X4, 4, 3, 1'b0);
    wait_done();
    chk("addr4_count", 32'(addr_log.size()), 9);
    for (int i = 0; i < 9 && i < addr_log.size(); i++) chk("addr4_seq", 32'(addr_log[i]), 32'(exp4[i]));
    chk("wr_pulses_4x4", 32'(wr_cnt), 1);

    // 8x8 back-to-back with start pokes during LOAD and SCAN
    begin_tile(SZ_8X8, 8, 2, 1'b1);
    wait_done();
    chk("done_once_8x8", 32'(done_cnt), 2);

    // 8x8 with backpressure on window (1,2)
    begin_tile(SZ_8X8, 8, 1, 1'b0);
    wait_win(1, 2);
    win_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(win_valid),  1);
      chk("bp_addr",  32'(addr_input), 10);
      chk("bp_rc",    32'({win_row, win_col}), 32'({6'd1, 6'd2}));
    end
    win_ready = 1'b1;
    wait_done();

    // Reset during window 20 of 8x8
    dc = done_cnt;
    begin_tile(SZ_8X8, 8, 1, 1'b0);
    wait_win(2, 6);
    rst = 1'b1;
    #1;
    chk("rst_mid_flags", 32'({busy, done, err, ld_req, win_valid, win_last, en_write_in}), 0);
    chk("rst_mid_addr",  32'(addr_input), 0);
    chk("rst_mid_rc",    32'({win_row, win_col}), 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_rst", 32'(done_cnt), 32'(dc));
    begin_tile(SZ_4X4, 4, 2, 1'b0);
    wait_done();

    @(posedge clk); #1;
    chk("total_done", 32'(done_cnt), 4);
    chk("total_wr",   32'(wr_cnt),   5);
    chk("queue_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
